mp_adder_ctrl: RTL and testbench

//  Sequencer for multi-precision addition on a single shared adder_nbit instance.

---
 rtl/mp_adder_ctrl_pkg.sv | 12 +
 rtl/mp_adder_ctrl_adder_nbit.sv | 15 +
 rtl/mp_adder_ctrl.sv | 116 +++++++++++
 tb/tb_mp_adder_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mp_adder_ctrl_pkg.sv
// Shared types for the multi-precision adder sequencer.
// Holds the FSM state encoding and the index-width helper.
package mp_adder_pkg;

  typedef enum logic [1:0] {IDLE, ADD, DONE} mp_state_t;

  // A single-slice configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mp_adder_ctrl_adder_nbit.sv
// Shared single-slice adder: WIDTH-bit sum plus carry-out.
// Purely combinational; the sequencer registers everything around it.
module adder_nbit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/mp_adder_ctrl.sv
// Multi-precision add sequencer: one WORD_WIDTH slice per clock, LSW first,
// on a single shared adder_nbit, with the slice carry chained through r_carry.
//
// state | meaning
// IDLE  | waiting for start; operands and carry_in latched on accept
// ADD   | one slice added per edge; last slice publishes sum_out/overflow
// DONE  | one-cycle done pulse, then back to IDLE
module mp_adder_ctrl
  import mp_adder_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_WORDS  = 4,
  localparam int TW        = WORD_WIDTH * NUM_WORDS,
  localparam int IDXW      = idx_width(NUM_WORDS)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic [TW-1:0] a_in,
  input  logic [TW-1:0] b_in,
  input  logic          carry_in,
  output logic          busy,
  output logic          done,
  output logic [TW-1:0] sum_out,
  output logic          overflow
);

  mp_state_t       r_state;
  logic [TW-1:0]   r_op_a;
  logic [TW-1:0]   r_op_b;
  logic [TW-1:0]   r_res;
  logic [TW-1:0]   r_sum;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic            r_busy;
  logic            r_done;
  logic            r_ovf;

  logic [WORD_WIDTH-1:0] w_slice_sum;
  logic                  w_slice_ovf;
  logic [TW-1:0]         w_full;
  logic                  w_last;

  adder_nbit #(.WIDTH(WORD_WIDTH)) u_adder (
    .a        (r_op_a[WORD_WIDTH-1:0]),
    .b        (r_op_b[WORD_WIDTH-1:0]),
    .carry_in (r_carry),
    .sum      (w_slice_sum),
    .overflow (w_slice_ovf)
  );

  // Result including the slice being added this cycle, so the last edge
  // can publish the complete sum without an extra cycle.
  always_comb begin
    w_full = r_res;
    w_full[int'(r_idx) * WORD_WIDTH +: WORD_WIDTH] = w_slice_sum;
  end

  assign w_last = (r_idx == IDXW'(NUM_WORDS - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op_a  <= a_in;
            r_op_b  <= b_in;
            r_carry <= carry_in;
            r_idx   <= '0;
            r_res   <= '0;
            r_busy  <= 1'b1;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_res   <= w_full;
          r_carry <= w_slice_ovf;
          r_op_a  <= r_op_a >> WORD_WIDTH;
          r_op_b  <= r_op_b >> WORD_WIDTH;
          if (w_last) begin
            r_sum   <= w_full;
            r_ovf   <= w_slice_ovf;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum_out  = r_sum;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_mp_adder_ctrl.sv
// Self-checking bench for mp_adder_ctrl (WORD_WIDTH=8, NUM_WORDS=4).
// Table-driven vectors, hand-written multi-cycle sequences and a random sweep.
module tb_mp_adder_ctrl;

  localparam int WW = 8;
  localparam int NW = 4;
  localparam int TW = WW * NW;

  logic          clk;
  logic          n_rst;
  logic          start;
  logic [TW-1:0] a_in;
  logic [TW-1:0] b_in;
  logic          carry_in;
  logic          busy;
  logic          done;
  logic [TW-1:0] sum_out;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int cyc      = 0;
  logic [TW:0] prev_out = '0;

  mp_adder_ctrl #(.WORD_WIDTH(WW), .NUM_WORDS(NW)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .carry_in (carry_in),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // sum_out/overflow may only move on the edge that raises done.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (done) done_cnt++;
    if (n_rst && !done) check("hold_between_done", {overflow, sum_out}, prev_out);
    prev_out = {overflow, sum_out};
  end

  // Starts an op from IDLE and waits for done; lat = edges after the accept edge.
  task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin,
                        output logic [TW-1:0] s, output logic o, output int lat);
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; carry_in = cin;
    @(negedge clk);
    start = 1'b0; a_in = $urandom; b_in = $urandom; carry_in = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    s = sum_out;
    o = overflow;
  endtask

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cin;
    logic [TW-1:0] sum;
    logic          ovf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [TW-1:0] s;
    logic          o;
    int            lat;
    int            snap;
    int            t_done[2];
    int            nd;
    logic [TW:0]   ref_v;
    logic [TW-1:0] ra, rb;
    logic          rc;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};
    vecs[8] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0};

    n_rst = 1'b0; start = 1'b0; a_in = '0; b_in = '0; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum_out, 0);
    check("rst_ovf", overflow, 0);
    n_rst = 1'b1;

    // done rises on edge t4 after accept and is gone after t5
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, o, lat);
      check($sformatf("vec%0d_sum", i), s, vecs[i].sum);
      check($sformatf("vec%0d_ovf", i), o, vecs[i].ovf);
      check($sformatf("vec%0d_latency", i), lat, NW);
      check($sformatf("vec%0d_busy_in_done", i), busy, 1);
      @(negedge clk);
      check($sformatf("vec%0d_done_one_cycle", i), done, 0);
      check($sformatf("vec%0d_idle_busy", i), busy, 0);
    end

    // Reset after two slices: in-flight op discarded, prior result cleared.
    @(negedge clk);
    start = 1'b1; a_in = 32'h1234_5678; b_in = 32'h1111_1111; carry_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("midop_busy_before_rst", busy, 1);
    n_rst = 1'b0;
    #1;
    check("midop_rst_busy", busy, 0);
    check("midop_rst_done", done, 0);
    check("midop_rst_sum", sum_out, 0);
    check("midop_rst_ovf", overflow, 0);
    @(negedge clk);
    n_rst = 1'b1;
    snap = done_cnt;
    repeat (3) @(negedge clk);
    check("midop_no_done", done_cnt - snap, 0);
    check("midop_idle_busy", busy, 0);
    check("midop_idle_sum", sum_out, 0);
    check("midop_idle_ovf", overflow, 0);

    // start during ADD and during DONE must be ignored.
    snap = done_cnt;
    @(negedge clk);
    start = 1'b1; a_in = 32'h1234_5678; b_in = 32'h1111_1111; carry_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a_in = 32'hFFFF_FFFF; b_in = 32'h0000_0001; carry_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check("busy_start_done_seen", lat >= 0, 1);
    start = 1'b1; a_in = 32'hAAAA_AAAA; b_in = 32'h5555_5555; carry_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_start_one_done", done_cnt - snap, 1);
    check("busy_start_sum", sum_out, 32'h2345_6789);
    check("busy_start_ovf", overflow, 0);
    check("busy_start_idle", busy, 0);

    // Back-to-back with start held high: done pulses 6 cycles apart.
    @(negedge clk);
    start = 1'b1; a_in = 32'h0000_00FF; b_in = 32'h0000_0001; carry_in = 1'b0;
    @(negedge clk);
    a_in = 32'hFFFF_FFFF; b_in = 32'h0000_0000; carry_in = 1'b1;
    nd = 0;
    t_done[0] = 0; t_done[1] = 0;
    for (int k = 0; k < 30 && nd < 2; k++) begin
      @(negedge clk);
      if (done) begin
        t_done[nd] = cyc;
        if (nd == 0) begin
          check("b2b_op1_sum", sum_out, 32'h0000_0100);
          check("b2b_op1_ovf", overflow, 0);
        end else begin
          start = 1'b0;
          check("b2b_op2_sum", sum_out, 32'h0000_0000);
          check("b2b_op2_ovf", overflow, 1);
        end
        nd++;
      end else if (nd == 1) begin
        check("b2b_op1_held", {overflow, sum_out}, {1'b0, 32'h0000_0100});
      end
    end
    start = 1'b0;
    check("b2b_two_dones", nd, 2);
    check("b2b_spacing", t_done[1] - t_done[0], 6);
    repeat (2) @(negedge clk);

    // Random sweep against the {ovf,sum} = a + b + cin model.
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      ref_v = {1'b0, ra} + {1'b0, rb} + {{TW{1'b0}}, rc};
      run_op(ra, rb, rc, s, o, lat);
      check("rand_result", {lat == NW, o, s}, {1'b1, ref_v});
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
